// File: rtl/rom_fetch_pkg.sv
// Shared types and constants for the ROM fetch/load sequencing controller.
package rom_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LD = 1'b1
  } port_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned WORD_BYTES = 4;

  // Number of byte reads for a load; the reserved encoding reads a full word.
  function automatic logic [2:0] size_to_n(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rom_fetch_ctrl_arbiter.sv
// Two-requester round-robin arbiter; bit 0 is instruction fetch, bit 1 is data load.
module rom_rr_arbiter
  import rom_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_e last_grant_q;

  // On a tie the port that was not served last wins.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i && (req_i == 2'b11)) begin
      gnt_o = (last_grant_q == PORT_LD) ? 2'b01 : 2'b10;
    end else if (en_i) begin
      gnt_o = req_i;
    end else begin
      gnt_o = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= PORT_LD;
    end else if (|gnt_o) begin
      last_grant_q <= gnt_o[1] ? PORT_LD : PORT_IF;
    end else begin
      last_grant_q <= last_grant_q;
    end
  end

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Shares the byte-wide ROM between instruction fetch and data load, assembling LE words.
// Optional one-entry fetch buffer enabled by defining ROM_FETCH_BUF_EN.
module rom_fetch_ctrl
  import rom_fetch_pkg::*;
#(
  parameter int unsigned ROM_BYTES = 112
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [1:0]  ld_size,
  output logic        ld_ack,
  output logic [31:0] ld_data,
  output logic [31:0] rom_address,
  input  logic [7:0]  rom_byte
);

  if (ROM_BYTES == 0) begin : g_rom_bytes_chk
    $error("ROM_BYTES must be nonzero");
  end

  state_e      state_q, state_d;
  port_e       port_q, port_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] rsp_q, rsp_d, rom_addr_q, rom_addr_d;
  logic [31:0] if_data_q, if_data_d, ld_data_q, ld_data_d;
  logic        if_ack_q, if_ack_d, ld_ack_q, ld_ack_d;
  logic [1:0]  gnt_s;
  logic        last_byte_s, hit_s;
  logic [31:0] byte_word_s, rsp_next_s, hit_word_s;

  rom_rr_arbiter u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == IDLE),
    .req_i ({ld_req, if_req}),
    .gnt_o (gnt_s)
  );

  assign last_byte_s = ({1'b0, cnt_q} == (n_q - 3'd1));
  assign byte_word_s = {24'd0, rom_byte} << {cnt_q, 3'b000};
  assign rsp_next_s  = rsp_q | byte_word_s;

`ifdef ROM_FETCH_BUF_EN
  logic        buf_valid_q, buf_valid_d, fill_s;
  logic [31:0] buf_tag_q, buf_tag_d, buf_word_q, buf_word_d, base_q, base_d;

  assign hit_s      = gnt_s[0] && buf_valid_q && (if_addr == buf_tag_q);
  assign hit_word_s = buf_word_q;
  assign fill_s     = (state_q == READ) && last_byte_s && (port_q == PORT_IF);

  // Buffer captures every completed fetch, tagged with its latched base address.
  always_comb begin
    base_d      = base_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_word_d  = buf_word_q;
    if ((state_q == IDLE) && gnt_s[0]) begin
      base_d = if_addr;
    end else if (fill_s) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = base_q;
      buf_word_d  = rsp_next_s;
    end else begin
      base_d = base_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= 32'd0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= 32'd0;
      buf_word_q  <= 32'd0;
    end else begin
      base_q      <= base_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_word_q  <= buf_word_d;
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_word_s = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|gnt_s) begin
          state_d = hit_s ? RESP : READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (last_byte_s) begin
          state_d = RESP;
        end else begin
          state_d = READ;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Acks are computed a cycle early so they are registered and high only in RESP.
  always_comb begin
    port_d     = port_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    rsp_d      = rsp_q;
    rom_addr_d = rom_addr_q;
    if_data_d  = if_data_q;
    ld_data_d  = ld_data_q;
    if_ack_d   = 1'b0;
    ld_ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt_s) begin
          port_d = gnt_s[1] ? PORT_LD : PORT_IF;
          n_d    = gnt_s[1] ? size_to_n(ld_size) : 3'(WORD_BYTES);
          cnt_d  = 2'd0;
          rsp_d  = 32'd0;
          if (hit_s) begin
            if_data_d = hit_word_s;
            if_ack_d  = 1'b1;
          end else begin
            rom_addr_d = gnt_s[1] ? ld_addr : if_addr;
          end
        end else begin
          cnt_d = 2'd0;
        end
      end
      READ: begin
        rsp_d = rsp_next_s;
        if (last_byte_s) begin
          cnt_d = 2'd0;
          if (port_q == PORT_IF) begin
            if_data_d = rsp_next_s;
            if_ack_d  = 1'b1;
          end else begin
            ld_data_d = rsp_next_s;
            ld_ack_d  = 1'b1;
          end
        end else begin
          cnt_d      = cnt_q + 2'd1;
          rom_addr_d = rom_addr_q + 32'd1;
        end
      end
      RESP:    cnt_d = 2'd0;
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q     <= PORT_IF;
      cnt_q      <= 2'd0;
      n_q        <= 3'd4;
      rsp_q      <= 32'd0;
      rom_addr_q <= 32'd0;
      if_data_q  <= 32'd0;
      ld_data_q  <= 32'd0;
      if_ack_q   <= 1'b0;
      ld_ack_q   <= 1'b0;
    end else begin
      port_q     <= port_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      rsp_q      <= rsp_d;
      rom_addr_q <= rom_addr_d;
      if_data_q  <= if_data_d;
      ld_data_q  <= ld_data_d;
      if_ack_q   <= if_ack_d;
      ld_ack_q   <= ld_ack_d;
    end
  end

  assign if_ack      = if_ack_q;
  assign ld_ack      = ld_ack_q;
  assign if_data     = if_data_q;
  assign ld_data     = ld_data_q;
  assign rom_address = rom_addr_q;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed, table-driven bench for rom_fetch_ctrl; the ROM model returns the low address byte.
module tb_rom_fetch_ctrl;
  import rom_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ld_req, if_ack, ld_ack;
  logic [31:0] if_addr, ld_addr, if_data, ld_data, rom_address;
  logic [1:0]  ld_size;
  logic [7:0]  rom_byte;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_if = 32'd0;
  logic [31:0] exp_ld = 32'd0;

  typedef struct {
    logic        is_ld;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] exp_data;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  int          ev_n;
  int          ev_cyc[4];
  logic        ev_port[4];
  logic [31:0] ev_dat[4];
  logic        both_seen;
  int          exp_cyc[4];
  logic        exp_port[4];
  logic [31:0] exp_dat[4];
  int          b2b_c1, b2b_c2;
  logic [31:0] b2b_d1, b2b_d2;

  rom_fetch_ctrl #(.ROM_BYTES(112)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_ack      (if_ack),
    .if_data     (if_data),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_size     (ld_size),
    .ld_ack      (ld_ack),
    .ld_data     (ld_data),
    .rom_address (rom_address),
    .rom_byte    (rom_byte)
  );

  always #5 clk = ~clk;
  assign rom_byte = rom_address[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the controller idle; that cycle is cycle 0.
  task automatic run_one(input vec_t v, input string name);
    int   got = 0;
    logic other = 1'b0;
    if (v.is_ld) begin
      ld_req = 1'b1; ld_addr = v.addr; ld_size = v.size;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int k = 1; k <= 20 && got == 0; k++) begin
      @(posedge clk); #1;
      if (k < v.lat) chk($sformatf("%s addr c%0d", name, k), rom_address, v.addr + 32'(k - 1));
      if (v.is_ld ? if_ack : ld_ack) other = 1'b1;
      if (v.is_ld ? ld_ack : if_ack) got = k;
    end
    chk($sformatf("%s latency", name), 32'(got), 32'(v.lat));
    chk($sformatf("%s data", name), v.is_ld ? ld_data : if_data, v.exp_data);
    if (v.is_ld) exp_ld = v.exp_data; else exp_if = v.exp_data;
    if_req = 1'b0; ld_req = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s ack width", name), {30'd0, if_ack, ld_ack}, 32'd0);
    chk($sformatf("%s other ack", name), {31'd0, other}, 32'd0);
    chk($sformatf("%s if_data hold", name), if_data, exp_if);
    chk($sformatf("%s ld_data hold", name), ld_data, exp_ld);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    exp_if = 32'd0; exp_ld = 32'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0010, SZ_BYTE, 32'h1312_1110, 5};
    vecs[1] = '{1'b1, 32'hFFFF_FFFE, SZ_HALF, 32'h0000_FFFE, 3};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, SZ_WORD, 32'h0201_00FF, 5};
    vecs[3] = '{1'b1, 32'h0000_0045, SZ_BYTE, 32'h0000_0045, 2};
    vecs[4] = '{1'b1, 32'h0000_0031, 2'd3,    32'h3433_3231, 5};
    vecs[5] = '{1'b0, 32'hFFFF_FFFD, SZ_BYTE, 32'h00FF_FEFD, 5};
    vecs[6] = '{1'b1, 32'h0000_0080, SZ_HALF, 32'h0000_8180, 3};
    exp_cyc  = '{5, 8, 14, 17};
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_dat  = '{32'h0302_0100, 32'h0000_0020, 32'h4342_4140, 32'h0000_0020};

    rst_n = 1'b0; if_req = 1'b0; ld_req = 1'b0;
    if_addr = 32'd0; ld_addr = 32'd0; ld_size = SZ_BYTE;
    repeat (3) @(posedge clk);
    #1;
    chk("reset acks", {30'd0, if_ack, ld_ack}, 32'd0);
    chk("reset if_data", if_data, 32'd0);
    chk("reset ld_data", ld_data, 32'd0);
    chk("reset rom_address", rom_address, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests after reset: fetch first, then strict alternation.
    do_reset();
    ev_n = 0; both_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ev_cyc[i] = 0; ev_port[i] = 1'b0; ev_dat[i] = 32'd0;
    end
    if_req = 1'b1; if_addr = 32'h0000_0000;
    ld_req = 1'b1; ld_addr = 32'h0000_0020; ld_size = SZ_BYTE;
    for (int k = 1; k <= 30 && ev_n < 4; k++) begin
      @(posedge clk); #1;
      if (if_ack && ld_ack) both_seen = 1'b1;
      if (if_ack) begin
        ev_cyc[ev_n] = k; ev_port[ev_n] = 1'b0; ev_dat[ev_n] = if_data; ev_n++;
        if_addr = 32'h0000_0040;
      end else if (ld_ack) begin
        ev_cyc[ev_n] = k; ev_port[ev_n] = 1'b1; ev_dat[ev_n] = ld_data; ev_n++;
      end
    end
    if_req = 1'b0; ld_req = 1'b0;
    chk("tie ack count", 32'(ev_n), 32'd4);
    chk("tie both acks", {31'd0, both_seen}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie%0d cycle", i), 32'(ev_cyc[i]), 32'(exp_cyc[i]));
      chk($sformatf("tie%0d port", i), {31'd0, ev_port[i]}, {31'd0, exp_port[i]});
      chk($sformatf("tie%0d data", i), ev_dat[i], exp_dat[i]);
    end
    exp_if = 32'h4342_4140; exp_ld = 32'h0000_0020;
    @(posedge clk); #1;

    // Reset in the middle of a fetch; held request is re-served afterwards.
    if_req = 1'b1; if_addr = 32'h0000_0050;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; #1;
    chk("midrst if_ack", {31'd0, if_ack}, 32'd0);
    chk("midrst if_data", if_data, 32'd0);
    chk("midrst ld_data", ld_data, 32'd0);
    chk("midrst rom_address", rom_address, 32'd0);
    exp_if = 32'd0; exp_ld = 32'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_one('{1'b0, 32'h0000_0050, SZ_BYTE, 32'h5352_5150, 5}, "after_rst");

    // Back-to-back fetches with the request held across the first ack.
    b2b_c1 = 0; b2b_c2 = 0; b2b_d1 = 32'd0; b2b_d2 = 32'd0;
    if_req = 1'b1; if_addr = 32'h0000_0004;
    for (int k = 1; k <= 30 && b2b_c2 == 0; k++) begin
      @(posedge clk); #1;
      if (if_ack && b2b_c1 == 0) begin
        b2b_c1 = k; b2b_d1 = if_data; if_addr = 32'h0000_0008;
      end else if (if_ack) begin
        b2b_c2 = k; b2b_d2 = if_data;
      end
    end
    if_req = 1'b0;
    chk("b2b ack1 cycle", 32'(b2b_c1), 32'd5);
    chk("b2b ack2 cycle", 32'(b2b_c2), 32'd11);
    chk("b2b data1", b2b_d1, 32'h0706_0504);
    chk("b2b data2", b2b_d2, 32'h0B0A_0908);
    exp_if = 32'h0B0A_0908;
    @(posedge clk); #1;

`ifdef ROM_FETCH_BUF_EN
    run_one('{1'b0, 32'h0000_0010, SZ_BYTE, 32'h1312_1110, 5}, "buf_miss");
    run_one('{1'b0, 32'h0000_0010, SZ_BYTE, 32'h1312_1110, 1}, "buf_hit");
    chk("buf_hit rom_address", rom_address, 32'h0000_0013);
    run_one('{1'b0, 32'h0000_0014, SZ_BYTE, 32'h1716_1514, 5}, "buf_miss2");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
